// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates one entry per issued instruction, captures
// ALU/LSB results, retires in program order and flushes on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,

  input  logic                 transmit_from_issue,
  input  logic [4:0]           dest_from_issue,
  input  logic                 is_branch_from_issue,
  output logic [ROB_IDX_W-1:0] tail_to_issue,
  output logic                 full_to_issue,

  input  logic                 valid_from_alu,
  input  logic [ROB_IDX_W-1:0] rob_pos_from_alu,
  input  logic [31:0]          data_from_alu,
  input  logic                 mispredict_from_alu,
  input  logic [31:0]          target_from_alu,

  input  logic                 valid_from_lsb,
  input  logic [ROB_IDX_W-1:0] rob_pos_from_lsb,
  input  logic [31:0]          data_from_lsb,

  input  logic [ROB_IDX_W-1:0] rs1_pos_from_issue,
  input  logic [ROB_IDX_W-1:0] rs2_pos_from_issue,
  output logic                 rs1_rdy_to_issue,
  output logic                 rs2_rdy_to_issue,
  output logic [31:0]          rs1_data_to_issue,
  output logic [31:0]          rs2_data_to_issue,

  output logic                 write_to_regfile,
  output logic [4:0]           addr_to_regfile,
  output logic [ROB_IDX_W-1:0] rob_pos_to_regfile,
  output logic [31:0]          data_to_regfile,

  output logic                 flush_to_all,
  output logic [31:0]          pc_to_if
);

  localparam logic [ROB_IDX_W:0]   CNT_ONE  = (ROB_IDX_W+1)'(1);
  localparam logic [ROB_IDX_W:0]   CNT_FULL = (ROB_IDX_W+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_W-1:0] IDX_ONE  = ROB_IDX_W'(1);

  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [ROB_IDX_W:0]   count;

  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_ready;
  logic [ROB_DEPTH-1:0] ent_branch;
  logic [ROB_DEPTH-1:0] ent_mispredict;
  logic [4:0]           ent_dest   [ROB_DEPTH];
  logic [31:0]          ent_data   [ROB_DEPTH];
  logic [31:0]          ent_target [ROB_DEPTH];

  logic full;
  logic do_alloc;
  logic do_commit;
  logic do_flush;

  assign full          = (count == CNT_FULL);
  assign full_to_issue = full;
  assign tail_to_issue = tail;

  assign do_alloc  = transmit_from_issue && !full;
  assign do_commit = ent_valid[head] && ent_ready[head];
  assign do_flush  = do_commit && ent_branch[head] && ent_mispredict[head];

  // Pointers, occupancy flags and the registered commit/flush outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      ent_valid          <= '0;
      ent_ready          <= '0;
      write_to_regfile   <= 1'b0;
      addr_to_regfile    <= '0;
      rob_pos_to_regfile <= '0;
      data_to_regfile    <= '0;
      flush_to_all       <= 1'b0;
      pc_to_if           <= '0;
    end else if (rdy_in) begin
      write_to_regfile <= 1'b0;
      flush_to_all     <= 1'b0;

      if (do_commit) begin
        write_to_regfile   <= (ent_dest[head] != 5'd0);
        addr_to_regfile    <= ent_dest[head];
        rob_pos_to_regfile <= head;
        data_to_regfile    <= ent_data[head];
      end

      if (do_flush) begin
        // Same-cycle allocations and writebacks are dropped with the flush.
        flush_to_all <= 1'b1;
        pc_to_if     <= ent_target[head];
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        ent_valid    <= '0;
        ent_ready    <= '0;
      end else begin
        if (do_commit) begin
          ent_valid[head] <= 1'b0;
          head            <= head + IDX_ONE;
        end

        if (valid_from_alu) ent_ready[rob_pos_from_alu] <= 1'b1;
        if (valid_from_lsb) ent_ready[rob_pos_from_lsb] <= 1'b1;

        if (do_alloc) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= 1'b0;
          tail            <= tail + IDX_ONE;
        end

        if (do_alloc && !do_commit)      count <= count + CNT_ONE;
        else if (!do_alloc && do_commit) count <= count - CNT_ONE;
      end
    end
  end

  // Payload storage: validity is tracked above, so no reset is needed here.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !do_flush) begin
      if (do_alloc) begin
        ent_dest[tail]       <= dest_from_issue;
        ent_branch[tail]     <= is_branch_from_issue;
        ent_mispredict[tail] <= 1'b0;
      end
      if (valid_from_alu) begin
        ent_data[rob_pos_from_alu]       <= data_from_alu;
        ent_mispredict[rob_pos_from_alu] <= mispredict_from_alu;
        ent_target[rob_pos_from_alu]     <= target_from_alu;
      end
      if (valid_from_lsb) begin
        ent_data[rob_pos_from_lsb] <= data_from_lsb;
      end
    end
  end

  // Operand lookup with same-cycle bypass: ALU bus, then LSB bus, then storage.
  function automatic logic [32:0] lookup(input logic [ROB_IDX_W-1:0] pos,
                                         input logic                 stored_rdy,
                                         input logic [31:0]          stored_data);
    logic [32:0] res;
    res = '0;
    if (valid_from_alu && rob_pos_from_alu == pos)      res = {1'b1, data_from_alu};
    else if (valid_from_lsb && rob_pos_from_lsb == pos) res = {1'b1, data_from_lsb};
    else if (stored_rdy)                                res = {1'b1, stored_data};
    return res;
  endfunction

  always_comb begin
    logic [32:0] r1;
    logic [32:0] r2;
    r1 = lookup(rs1_pos_from_issue, ent_ready[rs1_pos_from_issue], ent_data[rs1_pos_from_issue]);
    r2 = lookup(rs2_pos_from_issue, ent_ready[rs2_pos_from_issue], ent_data[rs2_pos_from_issue]);
    rs1_rdy_to_issue  = r1[32];
    rs1_data_to_issue = r1[31:0];
    rs2_rdy_to_issue  = r2[32];
    rs2_data_to_issue = r2[31:0];
  end

endmodule
